// File: rtl/ternary_fold_unit_if.sv
// rtl/ternary_fold_unit_if.sv - trit stream in, folded result out
// Ports (signals):
//   in_valid/in_ready  input beat handshake
//   in0/in1            input trit (2-bit code; 11 illegal)
//   in_last            final beat of packet
//   op                 0 = MAX, 1 = CONSENSUS (first beat only)
//   out_valid/out_ready result handshake
//   out0/out1          result trit
//   out_len            beats accepted in packet (saturating)
//   out_err            illegal trit seen or counter overflowed
// master = producer/consumer side, slave = fold unit side.
interface ternary_fold_unit_if #(
  parameter int CNT_W = 8
) ();
  logic             in_valid;
  logic             in_ready;
  logic             in0;
  logic             in1;
  logic             in_last;
  logic             op;
  logic             out_valid;
  logic             out_ready;
  logic             out0;
  logic             out1;
  logic [CNT_W-1:0] out_len;
  logic             out_err;

  modport master (
    output in_valid, in0, in1, in_last, op, out_ready,
    input  in_ready, out_valid, out0, out1, out_len, out_err
  );

  modport slave (
    input  in_valid, in0, in1, in_last, op, out_ready,
    output in_ready, out_valid, out0, out1, out_len, out_err
  );
endinterface

// File: rtl/ternary_fold_unit.sv
// rtl/ternary_fold_unit.sv - serial MAX/CONSENSUS fold of a trit packet
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  ternary_fold_unit_if.slave (input trit stream, result output)
// One result per packet is held in HOLD until out_ready; in_ready is
// decoded from state only, so there is no combinational out_ready path.
module ternary_fold_unit #(
  parameter int CNT_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  ternary_fold_unit_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LEN_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] LEN_ONE = CNT_W'(1);

  state_t           state_q, state_d;
  logic [1:0]       acc_q, acc_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic             err_q, err_d;
  logic             empty_q, empty_d;  // no legal trit folded yet
  logic             op_q, op_d;

  logic [1:0] trit;
  logic       illegal;

  assign trit    = {bus.in1, bus.in0};
  assign illegal = (trit == 2'b11);

  // Both operands are always legal codes here, so a plain compare is max.
  function automatic logic [1:0] fold(input logic op_sel,
                                      input logic [1:0] a,
                                      input logic [1:0] b);
    if (op_sel)
      return (a == b) ? a : 2'b01;
    else
      return (a > b) ? a : b;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= 2'b00;
      len_q   <= '0;
      err_q   <= 1'b0;
      empty_q <= 1'b0;
      op_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      len_q   <= len_d;
      err_q   <= err_d;
      empty_q <= empty_d;
      op_q    <= op_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    len_d   = len_q;
    err_d   = err_q;
    empty_d = empty_q;
    op_d    = op_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          op_d    = bus.op;
          len_d   = LEN_ONE;
          err_d   = illegal;
          empty_d = illegal;
          acc_d   = illegal ? 2'b00 : trit;
          state_d = bus.in_last ? HOLD : ACCUM;
        end
      end
      ACCUM: begin
        if (bus.in_valid) begin
          if (len_q == LEN_MAX)
            err_d = 1'b1;
          else
            len_d = len_q + LEN_ONE;
          if (illegal) begin
            err_d = 1'b1;
          end else if (empty_q) begin
            acc_d   = trit;
            empty_d = 1'b0;
          end else begin
            acc_d = fold(op_q, acc_q, trit);
          end
          if (bus.in_last)
            state_d = HOLD;
        end
      end
      HOLD: begin
        if (bus.out_ready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready  = (state_q != HOLD);
  assign bus.out_valid = (state_q == HOLD);
  assign bus.out0      = acc_q[0];
  assign bus.out1      = acc_q[1];
  assign bus.out_len   = len_q;
  assign bus.out_err   = err_q;

endmodule

// File: tb/tb_ternary_fold_unit.sv
// tb/tb_ternary_fold_unit.sv - directed bench for ternary_fold_unit
module tb_ternary_fold_unit;

  logic clk;
  logic rst;

  int tests_run;
  int tests_failed;

  ternary_fold_unit_if #(.CNT_W(8)) bus ();
  ternary_fold_unit_if #(.CNT_W(2)) sbus ();

  ternary_fold_unit #(.CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  ternary_fold_unit #(.CNT_W(2)) dut_sat (
    .clk (clk),
    .rst (rst),
    .bus (sbus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] t, input logic last, input logic o);
    int n;
    bus.in_valid = 1'b1;
    bus.in1      = t[1];
    bus.in0      = t[0];
    bus.in_last  = last;
    bus.op       = o;
    n = 0;
    while (!bus.in_ready && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) check("in_ready_timeout", {31'd0, bus.in_ready}, 32'd1);
    tick();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic bubble();
    bus.in_valid = 1'b0;
    bus.in1      = 1'b1;
    bus.in0      = 1'b1;
    bus.in_last  = 1'b1;
    tick();
    bus.in_last  = 1'b0;
  endtask

  task automatic take_result(input string tag, input logic [1:0] r,
                             input logic [7:0] len, input logic err);
    check({tag, "_valid"}, {31'd0, bus.out_valid}, 32'd1);
    check({tag, "_out"}, {30'd0, bus.out1, bus.out0}, {30'd0, r});
    check({tag, "_len"}, {24'd0, bus.out_len}, {24'd0, len});
    check({tag, "_err"}, {31'd0, bus.out_err}, {31'd0, err});
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check({tag, "_drop"}, {31'd0, bus.out_valid}, 32'd0);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in0       = 1'b0;
    bus.in1       = 1'b0;
    bus.in_last   = 1'b0;
    bus.op        = 1'b0;
    bus.out_ready = 1'b0;
    sbus.in_valid  = 1'b0;
    sbus.in0       = 1'b0;
    sbus.in1       = 1'b0;
    sbus.in_last   = 1'b0;
    sbus.op        = 1'b0;
    sbus.out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    check("rst_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_out", {30'd0, bus.out1, bus.out0}, 32'd0);
    check("rst_len", {24'd0, bus.out_len}, 32'd0);
    check("rst_err", {31'd0, bus.out_err}, 32'd0);
    check("rst_ready", {31'd0, bus.in_ready}, 32'd1);

    // MAX 1,0,2 -> 2
    send(2'b01, 1'b0, 1'b0);
    send(2'b00, 1'b0, 1'b0);
    send(2'b10, 1'b1, 1'b0);
    take_result("max", 2'b10, 8'd3, 1'b0);

    // CONSENSUS agree then disagree
    send(2'b10, 1'b0, 1'b1);
    send(2'b10, 1'b0, 1'b1);
    send(2'b10, 1'b1, 1'b1);
    take_result("cons_agree", 2'b10, 8'd3, 1'b0);
    send(2'b10, 1'b0, 1'b1);
    send(2'b00, 1'b1, 1'b1);
    take_result("cons_dis", 2'b01, 8'd2, 1'b0);

    // single beat, illegal handling
    send(2'b00, 1'b1, 1'b1);
    take_result("single", 2'b00, 8'd1, 1'b0);
    send(2'b11, 1'b0, 1'b0);
    send(2'b01, 1'b1, 1'b0);
    take_result("ill_first", 2'b01, 8'd2, 1'b1);
    send(2'b11, 1'b1, 1'b0);
    take_result("ill_only", 2'b00, 8'd1, 1'b1);

    // backpressure with a pending next beat
    send(2'b10, 1'b1, 1'b0);
    bus.in_valid = 1'b1;
    bus.in1      = 1'b1;
    bus.in0      = 1'b0;
    bus.in_last  = 1'b0;
    bus.op       = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_ready", {31'd0, bus.in_ready}, 32'd0);
      check("bp_valid", {31'd0, bus.out_valid}, 32'd1);
      check("bp_out", {30'd0, bus.out1, bus.out0}, 32'd2);
      check("bp_len", {24'd0, bus.out_len}, 32'd1);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("bp_drop", {31'd0, bus.out_valid}, 32'd0);
    check("bp_ready_back", {31'd0, bus.in_ready}, 32'd1);
    tick();
    bus.in_valid = 1'b0;
    // op=1 sampled on the first beat; op=0 here must be ignored: cons(2,0)=1
    send(2'b00, 1'b1, 1'b0);
    take_result("bp_fresh_op", 2'b01, 8'd2, 1'b0);

    // bubbles with garbage on the data lines
    send(2'b01, 1'b0, 1'b0);
    bubble();
    bubble();
    send(2'b10, 1'b1, 1'b0);
    take_result("bubble", 2'b10, 8'd2, 1'b0);

    // reset mid-packet
    send(2'b01, 1'b0, 1'b0);
    send(2'b10, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mrst_valid", {31'd0, bus.out_valid}, 32'd0);
    check("mrst_out", {30'd0, bus.out1, bus.out0}, 32'd0);
    check("mrst_len", {24'd0, bus.out_len}, 32'd0);
    check("mrst_err", {31'd0, bus.out_err}, 32'd0);
    check("mrst_ready", {31'd0, bus.in_ready}, 32'd1);
    send(2'b01, 1'b1, 1'b0);
    take_result("after_rst", 2'b01, 8'd1, 1'b0);

    // saturation on the CNT_W=2 instance: 5 beats of 01
    sbus.in_valid = 1'b1;
    sbus.in1      = 1'b0;
    sbus.in0      = 1'b1;
    sbus.op       = 1'b0;
    for (int i = 0; i < 5; i++) begin
      sbus.in_last = (i == 4);
      tick();
    end
    sbus.in_valid = 1'b0;
    sbus.in_last  = 1'b0;
    check("sat_valid", {31'd0, sbus.out_valid}, 32'd1);
    check("sat_out", {30'd0, sbus.out1, sbus.out0}, 32'd1);
    check("sat_len", {30'd0, sbus.out_len}, 32'd3);
    check("sat_err", {31'd0, sbus.out_err}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/ternary_fold_unit.md
Name: ternary_fold_unit

Overview:
- Sequential reduction stage that sits directly downstream of the ternary gate cells (ternary_max / ternary_consensus).
- Consumes a packet of 2-bit-encoded trits, one per beat, over a valid/ready stream.
- Folds each packet serially with either MAX or CONSENSUS.
- Emits one result trit, plus beat count and error flag, per packet, held until the consumer accepts it.

Parameters:
- CNT_W, 8, width of beat counter / out_len; saturates at 2^CNT_W-1.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  input beat valid.
- in_ready  output  1  unit can accept a beat.
- in0  input  1  trit bit 0 (set = value 1).
- in1  input  1  trit bit 1 (set = value 2).
- in_last  input  1  final beat of packet.
- op  input  1  0 = MAX, 1 = CONSENSUS; sampled on first beat of packet only.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out0  output  1  result trit bit 0.
- out1  output  1  result trit bit 1.
- out_len  output  CNT_W  number of beats accepted in packet (saturating).
- out_err  output  1  packet contained an illegal trit or overflowed the counter.

Behaviour:
- Trit encoding: 0 = {in1,in0}=00, 1 = 01, 2 = 10. Code 11 is illegal.
- MAX fold: result = max(acc, t).
- CONSENSUS fold: result = acc if acc == t, else 1 (01).
- Reset (rst=1 at posedge): state IDLE, packet discarded. Outputs: out_valid=0, out0=out1=0, out_len=0, out_err=0. in_ready=1 once in IDLE.
- Mid-packet or HOLD reset: partial packet / pending result lost; the next accepted beat starts a new packet.
- States:
  - IDLE: no packet open.
  - ACCUM: packet open.
  - HOLD: result pending.
- in_ready = 1 in IDLE and ACCUM, 0 in HOLD (decoded from state, no combinational path from out_ready).
- Beat accepted when in_valid & in_ready at posedge.
- IDLE + accept:
  - latch op, len=1, err=(trit==11), empty=(trit==11).
  - acc = trit if legal, else 00.
  - in_last=1 -> HOLD; else -> ACCUM.
- ACCUM + accept:
  - len = len+1, saturating at 2^CNT_W-1; a beat arriving at saturation sets err.
  - Legal trit: if empty, acc = trit and empty cleared; else acc = fold(acc, trit).
  - Illegal trit: acc unchanged, err set.
  - in_last=1 -> HOLD.
- ACCUM with no accept: hold all state. Bubbles (in_valid=0) are allowed anywhere in a packet.
- Latency: the beat with in_last accepted at edge t gives out_valid=1 after edge t, with out0/out1/out_len/out_err stable.
- HOLD: outputs held while out_ready=0. out_valid & out_ready at an edge -> IDLE, out_valid=0. The next beat can be accepted in the following cycle; one idle cycle per packet is required.
- Packet with no legal trit: result 00, out_err=1.
- op changes mid-packet are ignored.
- in0/in1/in_last are ignored when no beat is accepted.
- Result encoding is always legal (never 11).

Test Plan:
- MAX fold: rst 2 cycles, then op=0 beats 1,0,2(last) -> out_valid one cycle after last, out={1,0} (=2), out_len=3, out_err=0.
- CONSENSUS agree/disagree: op=1, beats 2,2,2(last) -> out=2, len=3. Then beats 2,0(last) -> out=1 (01), len=2, err=0.
- Single-beat and illegal handling:
  - op=1, beat 0 with last -> out=00, len=1, one-beat packet goes IDLE->HOLD.
  - beats 11,01(last) under MAX -> out=01, len=2, err=1.
  - beat 11(last) alone -> out=00, err=1.
- Backpressure: hold out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0, outputs stable. out_ready=1 -> out_valid drops next cycle, the following beat is accepted, and the new packet's op is sampled fresh.
- Bubbles and reset: packet 1,_,_,2(last) with in_valid gaps -> out=2, len=2. Separately, assert rst after 2 beats of a packet -> all outputs 0, in_ready=1; new packet 1(last) -> out=01, len=1.
- Saturation with CNT_W=2: 5 beats of 01 under MAX -> out_len=3, out_err=1, out=01.
